// File: rtl/glue_pkg.sv
// Shared types and constants for the 68000 bus glue logic.
package glue_pkg;

  localparam int ADDR_HI = 23;
  localparam int ADDR_LO = 12;
  localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXT,
    S_ACK,
    S_BERR
  } bus_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width for a region count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/glue_region_match.sv
// Combinational priority comparator over flattened base/mask vectors.
// Lowest matching region index wins.
module glue_region_match
  import glue_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int IDX_W       = idx_width(NUM_REGIONS)
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [NUM_REGIONS*ADDR_W-1:0] base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] mask,
  output logic                          hit,
  output logic [IDX_W-1:0]              index,
  output logic [NUM_REGIONS-1:0]        onehot
);

  // Scan regions in ascending order, keeping only the first hit.
  always_comb begin
    hit    = 1'b0;
    index  = '0;
    onehot = '0;
    for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
      if (!hit && (((addr ^ base[r*ADDR_W +: ADDR_W]) & mask[r*ADDR_W +: ADDR_W]) == '0)) begin
        hit       = 1'b1;
        index     = IDX_W'(r);
        onehot[r] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glue_bus_ctrl.sv
// 68000 bus-cycle controller: region decode, chip enables, wait-state or
// external DTACK generation with watchdog, and BERR on bad cycles.
module glue_bus_ctrl
  import glue_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int WAIT_W      = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [11:0]                   addr_in,
  input  logic [2:0]                    fc,
  input  logic                          as_n,
  input  logic                          read,
  input  logic                          dtack_ext_n,
  input  logic [NUM_REGIONS*12-1:0]     region_base,
  input  logic [NUM_REGIONS*12-1:0]     region_mask,
  input  logic [NUM_REGIONS*WAIT_W-1:0] region_wait,
  input  logic [NUM_REGIONS-1:0]        region_ext,
  input  logic [NUM_REGIONS-1:0]        region_supv,
  input  logic [NUM_REGIONS-1:0]        region_ro,
  output logic [NUM_REGIONS-1:0]        enable_n,
  output logic                          dtack_n,
  output logic                          berr_n,
  output logic                          busy
);

  localparam int IDX_W = idx_width(NUM_REGIONS);
  localparam int CNT_W = max_int(WAIT_W, $clog2(TIMEOUT));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TMO_M = CNT_W'(TIMEOUT - 2);

  bus_state_t              state;
  logic [CNT_W-1:0]        cnt;

  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic [NUM_REGIONS-1:0]  hit_onehot;
  logic [WAIT_W-1:0]       wait_sel;
  logic                    cpu_space;
  logic                    access_bad;

  glue_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W)
  ) u_match (
    .addr   (addr_in),
    .base   (region_base),
    .mask   (region_mask),
    .hit    (hit),
    .index  (hit_idx),
    .onehot (hit_onehot)
  );

  // Per-cycle decode of the winning region's attributes.
  always_comb begin
    cpu_space  = (fc == FC_CPU_SPACE);
    wait_sel   = region_wait[hit_idx*WAIT_W +: WAIT_W];
    access_bad = !hit
               || (region_supv[hit_idx] && !fc[2])
               || (region_ro[hit_idx] && !read);
  end

  // Bus-cycle state machine with registered outputs.
  // The wait counter is loaded with W-1 (W=0 goes straight to ACK) so that
  // DTACK lands exactly W cycles after the enable, counting from the decode edge.
  // The watchdog fires when the count would reach TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      enable_n <= '1;
      dtack_n  <= 1'b1;
      berr_n   <= 1'b1;
      busy     <= 1'b0;
    end else if (state != S_IDLE && as_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      enable_n <= '1;
      dtack_n  <= 1'b1;
      berr_n   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!as_n) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (cpu_space) begin
              state <= S_EXT;
            end else if (access_bad) begin
              state  <= S_BERR;
              berr_n <= 1'b0;
            end else if (region_ext[hit_idx]) begin
              state    <= S_EXT;
              enable_n <= ~hit_onehot;
            end else if (wait_sel == '0) begin
              state    <= S_ACK;
              enable_n <= ~hit_onehot;
              dtack_n  <= 1'b0;
            end else begin
              state    <= S_WAIT;
              enable_n <= ~hit_onehot;
              cnt      <= CNT_W'(wait_sel) - CNT_ONE;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state   <= S_ACK;
            dtack_n <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_EXT: begin
          if (!dtack_ext_n) begin
            state   <= S_ACK;
            dtack_n <= 1'b0;
          end else if (cnt == CNT_TMO_M) begin
            state    <= S_BERR;
            berr_n   <= 1'b0;
            enable_n <= '1;
            cnt      <= cnt + CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_ACK, S_BERR: begin
          state <= state;
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          enable_n <= '1;
          dtack_n  <= 1'b1;
          berr_n   <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glue_bus_ctrl.sv
// Directed testbench for glue_bus_ctrl with hand-computed expectations.
module tb_glue_bus_ctrl;

  logic        clk;
  logic        reset;
  logic [11:0] addr_in;
  logic [2:0]  fc;
  logic        as_n;
  logic        read;
  logic        dtack_ext_n;
  logic [47:0] region_base;
  logic [47:0] region_mask;
  logic [15:0] region_wait;
  logic [3:0]  region_ext;
  logic [3:0]  region_supv;
  logic [3:0]  region_ro;
  logic [3:0]  enable_n;
  logic        dtack_n;
  logic        berr_n;
  logic        busy;

  int vectors;
  int miscompares;

  glue_bus_ctrl #(
    .NUM_REGIONS (4),
    .WAIT_W      (4),
    .TIMEOUT     (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr_in     (addr_in),
    .fc          (fc),
    .as_n        (as_n),
    .read        (read),
    .dtack_ext_n (dtack_ext_n),
    .region_base (region_base),
    .region_mask (region_mask),
    .region_wait (region_wait),
    .region_ext  (region_ext),
    .region_supv (region_supv),
    .region_ro   (region_ro),
    .enable_n    (enable_n),
    .dtack_n     (dtack_n),
    .berr_n      (berr_n),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [3:0] en, input logic dt,
                      input logic be, input logic bz);
    chk({tag, ".enable_n"}, {28'h0, enable_n}, {28'h0, en});
    chk({tag, ".dtack_n"},  {31'h0, dtack_n},  {31'h0, dt});
    chk({tag, ".berr_n"},   {31'h0, berr_n},   {31'h0, be});
    chk({tag, ".busy"},     {31'h0, busy},     {31'h0, bz});
  endtask

  task automatic start(input logic [11:0] a, input logic [2:0] f, input logic rd);
    addr_in = a;
    fc      = f;
    read    = rd;
    as_n    = 1'b0;
    tick();
  endtask

  task automatic finish_cycle(input string tag);
    as_n = 1'b1;
    tick();
    outs(tag, 4'hF, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    addr_in     = 12'h000;
    fc          = 3'b110;
    as_n        = 1'b1;
    read        = 1'b1;
    dtack_ext_n = 1'b1;
    // r3..r0
    region_base = {12'h400, 12'h800, 12'h000, 12'h800};
    region_mask = {12'hF00, 12'hF80, 12'hF00, 12'hF00};
    region_wait = {4'd0, 4'd2, 4'd3, 4'd1};
    region_ext  = 4'b1000;
    region_supv = 4'b0000;
    region_ro   = 4'b0000;

    tick();
    tick();
    outs("reset", 4'hF, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    tick();

    // Region 1, wait 3: enable right after decode, DTACK after 3 more edges.
    start(12'h042, 3'b110, 1'b1);
    outs("w3.dec", 4'b1101, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("w3.e2.dtack_n", {31'h0, dtack_n}, 32'h1);
    tick();
    outs("w3.ack", 4'b1101, 1'b0, 1'b1, 1'b1);
    tick();
    chk("w3.hold.dtack_n", {31'h0, dtack_n}, 32'h0);
    finish_cycle("w3.end");

    // Unmapped address.
    start(12'hFFF, 3'b110, 1'b1);
    outs("nohit", 4'hF, 1'b1, 1'b0, 1'b1);
    tick();
    outs("nohit.hold", 4'hF, 1'b1, 1'b0, 1'b1);
    finish_cycle("nohit.end");

    // Supervisor-only region accessed from user mode, then supervisor mode.
    region_supv = 4'b0010;
    start(12'h042, 3'b001, 1'b1);
    outs("supv.user", 4'hF, 1'b1, 1'b0, 1'b1);
    finish_cycle("supv.user.end");
    start(12'h042, 3'b101, 1'b1);
    outs("supv.sup", 4'b1101, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    chk("supv.sup.dtack_n", {31'h0, dtack_n}, 32'h0);
    finish_cycle("supv.sup.end");
    region_supv = 4'b0000;

    // Write to read-only region.
    region_ro = 4'b0010;
    start(12'h042, 3'b101, 1'b0);
    outs("ro.wr", 4'hF, 1'b1, 1'b0, 1'b1);
    finish_cycle("ro.wr.end");
    region_ro = 4'b0000;

    // External region, no acknowledge: BERR registered 63 edges after decode.
    start(12'h400, 3'b110, 1'b1);
    outs("tmo.dec", 4'b0111, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 62; i++) tick();
    outs("tmo.pre", 4'b0111, 1'b1, 1'b1, 1'b1);
    tick();
    outs("tmo.berr", 4'hF, 1'b1, 1'b0, 1'b1);
    finish_cycle("tmo.end");

    // External region acknowledged on the 5th edge after decode.
    start(12'h400, 3'b110, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("ext.pre.dtack_n", {31'h0, dtack_n}, 32'h1);
    dtack_ext_n = 1'b0;
    tick();
    outs("ext.ack", 4'b0111, 1'b0, 1'b1, 1'b1);
    dtack_ext_n = 1'b1;
    finish_cycle("ext.end");

    // Acknowledge on the very edge the watchdog would fire: ACK wins.
    start(12'h400, 3'b110, 1'b1);
    for (int i = 0; i < 62; i++) tick();
    dtack_ext_n = 1'b0;
    tick();
    outs("tmo.race", 4'b0111, 1'b0, 1'b1, 1'b1);
    dtack_ext_n = 1'b1;
    finish_cycle("tmo.race.end");

    // CPU space: external path, no enable even though no region matches.
    start(12'hFFF, 3'b111, 1'b1);
    outs("cpu.dec", 4'hF, 1'b1, 1'b1, 1'b1);
    dtack_ext_n = 1'b0;
    tick();
    outs("cpu.ack", 4'hF, 1'b0, 1'b1, 1'b1);
    dtack_ext_n = 1'b1;
    finish_cycle("cpu.end");

    // Overlap of regions 0 and 2: region 0 wins, wait 1.
    start(12'h842, 3'b110, 1'b1);
    outs("ovl.dec", 4'b1110, 1'b1, 1'b1, 1'b1);
    tick();
    chk("ovl.dtack_n", {31'h0, dtack_n}, 32'h0);
    finish_cycle("ovl.end");

    // Zero wait states: DTACK together with the enable.
    region_wait = {4'd0, 4'd2, 4'd3, 4'd0};
    start(12'h842, 3'b110, 1'b1);
    outs("w0.dec", 4'b1110, 1'b0, 1'b1, 1'b1);
    finish_cycle("w0.end");
    region_wait = {4'd0, 4'd2, 4'd3, 4'd1};

    // AS released during WAIT: no DTACK ever.
    start(12'h042, 3'b110, 1'b1);
    tick();
    as_n = 1'b1;
    tick();
    outs("abort", 4'hF, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    chk("abort.later.dtack_n", {31'h0, dtack_n}, 32'h1);

    // Reset during ACK, then a fresh cycle decodes normally.
    start(12'h842, 3'b110, 1'b1);
    tick();
    chk("rst.ack.dtack_n", {31'h0, dtack_n}, 32'h0);
    reset = 1'b1;
    tick();
    outs("rst.mid", 4'hF, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    tick();
    outs("rst.redec", 4'b1110, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rst.redec.dtack_n", {31'h0, dtack_n}, 32'h0);
    finish_cycle("rst.end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
